// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline encodings: instruction codes, status codes, register ids,
// controller state encoding and the hazard-term bundle.
package pipe_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [1:0] S_AOK    = 2'd0;
  localparam logic [1:0] S_HLT    = 2'd1;
  localparam logic [1:0] S_ADR    = 2'd2;
  localparam logic [1:0] S_INS    = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic lu;   // load/use
    logic ret;  // ret in flight
    logic mp;   // mispredicted branch
    logic exc;  // exception in M or W
  } hazard_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational decode of the load/use, ret, mispredict and exception hazard terms
// from the stage registers and decode-stage sources.
module pipe_hazard_detect
  import pipe_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_dstM,
  input  logic       e_cnd,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output hazard_t    haz
);

  logic e_is_load;

  always_comb begin
    e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
    haz.lu    = e_is_load && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    haz.ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    haz.mp    = (E_icode == I_JXX) && !e_cnd;
    haz.exc   = (m_stat != S_AOK) || (W_stat != S_AOK);
  end

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline sequencing controller: turns hazard terms into per-stage stall/bubble
// controls, freezes the pipe during slow data-memory accesses and latches halt status.
module pipe_ctrl_fsm
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic             dmem_busy,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       halt_stat,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_t           haz;
  ctrl_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]        halt_stat_nxt;
  logic              busy_entry;

  pipe_hazard_detect u_hazard (
    .D_icode (D_icode),
    .E_icode (E_icode),
    .M_icode (M_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_dstM  (E_dstM),
    .e_cnd   (e_cnd),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .haz     (haz)
  );

  // A busy access seen in RUN freezes the pipe already in that cycle.
  assign busy_entry = (state == ST_RUN) && dmem_busy && !haz.exc;
  assign halted     = (state == ST_HALT);

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    set_cc   = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_bubble = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          F_stall  = haz.lu | haz.ret;
          D_stall  = haz.lu;
          D_bubble = haz.mp | (haz.ret & ~haz.lu);
          E_bubble = haz.mp | haz.lu;
          M_bubble = haz.exc;
          W_stall  = (W_stat != S_AOK);
          set_cc   = (E_icode == I_OPQ) && !haz.exc;
          if (busy_entry) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_stall  = 1'b1;
          M_stall  = 1'b1;
          W_bubble = 1'b1;
        end
        default: begin
          F_stall = 1'b1;
          D_stall = 1'b1;
          E_stall = 1'b1;
          M_stall = 1'b1;
          W_stall = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    halt_stat_nxt = halt_stat;
    if (W_stat != S_AOK) begin
      // Status is captured only on entry so a later W_stat change cannot overwrite it.
      state_nxt = ST_HALT;
      if (state != ST_HALT) halt_stat_nxt = W_stat;
    end else begin
      case (state)
        ST_RUN: begin
          if (busy_entry) begin
            state_nxt    = ST_MEM_WAIT;
            wait_cnt_nxt = '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_busy) begin
            state_nxt = ST_RUN;
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST)) begin
            state_nxt     = ST_HALT;
            halt_stat_nxt = S_ADR;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      wait_cnt   <= '0;
      halt_stat  <= S_AOK;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      halt_stat <= halt_stat_nxt;
      if ((state == ST_RUN) && !busy_entry) begin
        if (F_stall)              stall_cnt  <= sat_inc(stall_cnt);
        if (D_bubble | E_bubble)  bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed plus randomized bench for pipe_ctrl_fsm against a behavioural model of the
// controller's hazard, memory-wait, halt and counter rules.
module tb_pipe_ctrl_fsm;

  localparam int CNT_W = 4;
  localparam int TO    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM;
  logic e_cnd, dmem_busy;
  logic [1:0] m_stat, W_stat;
  logic F_stall, D_stall, E_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, W_bubble, set_cc, halted;
  logic [1:0] halt_stat;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  int n_pass = 0;
  int n_total = 0;

  // model state: 0 = running, 1 = waiting on memory, 2 = halted
  int md, m_wc, m_sc, m_bc;
  logic [1:0] m_hs;

  always #5 clk = ~clk;

  pipe_ctrl_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM),
    .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat), .dmem_busy(dmem_busy),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
    .set_cc(set_cc), .halted(halted), .halt_stat(halt_stat),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic m_exc();
    return (m_stat != 2'd0) || (W_stat != 2'd0);
  endfunction

  // {F,D,E,M,W stall, D,E,M,W bubble, set_cc}
  function automatic logic [9:0] exp_ctrl();
    logic lu, rt, mp, ex;
    logic [9:0] v;
    lu = ((E_icode == 4'd5) || (E_icode == 4'd11)) && (E_dstM != 4'hF) &&
         ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mp = (E_icode == 4'd7) && !e_cnd;
    ex = m_exc();
    if (rst)     return 10'b00000_1111_0;
    if (md == 2) return 10'b11111_0000_0;
    if (md == 1) return 10'b11110_0001_0;
    v = {lu | rt, lu, 1'b0, 1'b0, W_stat != 2'd0,
         mp | (rt & !lu), mp | lu, ex, 1'b0, (E_icode == 4'd6) && !ex};
    if (dmem_busy && !ex) begin
      v[9:6] = 4'b1111;
      v[1]   = 1'b1;
    end
    return v;
  endfunction

  task automatic set_in(input logic [3:0] di, ei, mi, sa, sb, dm,
                        input logic cnd, input logic [1:0] ms, ws, input logic busy);
    D_icode = di; E_icode = ei; M_icode = mi;
    d_srcA = sa; d_srcB = sb; E_dstM = dm;
    e_cnd = cnd; m_stat = ms; W_stat = ws; dmem_busy = busy;
  endtask

  // Called #1 after a posedge: check mid-cycle, then advance model with the same inputs.
  task automatic step(input string tag);
    logic [9:0] c;
    logic ex;
    #3;
    c  = exp_ctrl();
    ex = m_exc();
    chk({tag, ".ctrl"}, {F_stall, D_stall, E_stall, M_stall, W_stall,
                         D_bubble, E_bubble, M_bubble, W_bubble, set_cc}, c);
    chk({tag, ".halted"}, halted, (md == 2));
    chk({tag, ".halt_stat"}, halt_stat, m_hs);
    chk({tag, ".stall_cnt"}, stall_cnt, m_sc);
    chk({tag, ".bubble_cnt"}, bubble_cnt, m_bc);
    @(posedge clk);
    if (rst) begin
      md = 0; m_wc = 0; m_hs = 2'd0; m_sc = 0; m_bc = 0;
    end else begin
      if (md == 0 && !(dmem_busy && !ex)) begin
        if (c[9] && m_sc < CMAX) m_sc++;
        if ((c[4] | c[3]) && m_bc < CMAX) m_bc++;
      end
      if (W_stat != 2'd0) begin
        if (md != 2) m_hs = W_stat;
        md = 2;
      end else if (md == 0) begin
        if (dmem_busy && !ex) begin md = 1; m_wc = 0; end
      end else if (md == 1) begin
        if (!dmem_busy) md = 0;
        else if (m_wc == TO - 1) begin md = 2; m_hs = 2'd2; end
        else m_wc++;
      end
    end
    #1;
  endtask

  function automatic logic [3:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  initial begin
    rst = 1'b1;
    set_in(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    md = 0; m_wc = 0; m_hs = 2'd0; m_sc = 0; m_bc = 0;
    step("reset");
    rst = 1'b0;
    step("idle");

    set_in(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 2'd0, 2'd0, 1'b0); step("lu_mrmovq");
    set_in(4'h1, 4'hB, 4'h1, 4'h2, 4'hF, 4'h4, 1'b1, 2'd0, 2'd0, 1'b0); step("popq_nolu");
    set_in(4'h1, 4'h5, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("rnone_nolu");
    set_in(4'h9, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("ret_D");
    set_in(4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("ret_E");
    set_in(4'h1, 4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("ret_M");
    set_in(4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("ret_done");
    set_in(4'h9, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 2'd0, 2'd0, 1'b0); step("ret_lu");
    set_in(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0, 2'd0, 1'b0); step("jxx_mp");
    set_in(4'h1, 4'h7, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("jxx_taken");
    set_in(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd2, 2'd0, 1'b0); step("opq_exc");
    set_in(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b0); step("opq_cc");

    set_in(4'h1, 4'h6, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 2'd0, 2'd0, 1'b1);
    repeat (4) step("mem_busy");
    dmem_busy = 1'b0; step("mem_release");
    chk("mem_back_to_run", halted, 1'b0);

    dmem_busy = 1'b1;
    repeat (8) step("mem_timeout");
    chk("timeout_halted", halted, 1'b1);
    chk("timeout_stat", halt_stat, 2'd2);
    rst = 1'b1; step("rst_after_timeout");
    rst = 1'b0; dmem_busy = 1'b0; step("run_after_rst");

    dmem_busy = 1'b1;
    repeat (2) step("wait_then_hlt");
    W_stat = 2'd1; step("w_shlt");
    W_stat = 2'd0; dmem_busy = 1'b0;
    repeat (3) step("halt_sticky");
    chk("shlt_stat", halt_stat, 2'd1);
    rst = 1'b1; step("rst_from_halt");
    rst = 1'b0; step("run_cleared");
    chk("cnt_cleared", stall_cnt, '0);

    set_in(4'h1, 4'h5, 4'h1, 4'h3, 4'hF, 4'h3, 1'b0, 2'd0, 2'd0, 1'b0);
    repeat (20) step("saturate");
    chk("stall_sat", stall_cnt, CMAX);
    chk("bubble_sat", bubble_cnt, CMAX);

    rst = 1'b1; step("rst_random");
    for (int i = 0; i < 400; i++) begin
      rst       = (md == 2) || ($urandom_range(0, 60) == 0);
      D_icode   = 4'($urandom_range(0, 11));
      E_icode   = 4'($urandom_range(0, 11));
      M_icode   = 4'($urandom_range(0, 11));
      d_srcA    = rreg();
      d_srcB    = rreg();
      E_dstM    = rreg();
      e_cnd     = 1'($urandom_range(0, 1));
      m_stat    = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat    = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      dmem_busy = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
